// File: rtl/rr_bus_arb.sv
// Round-robin arbiter: NREQ masters share one slave through a two-state
// IDLE/BUSY transfer engine with a slave-ack timeout.
module rr_bus_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int TMO  = 16
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic [NREQ-1:0]    m_req_i,
    input  logic [NREQ-1:0]    m_we_i,
    input  logic [NREQ*AW-1:0] m_addr_i,
    input  logic [NREQ*DW-1:0] m_wd_i,
    output logic [NREQ-1:0]    m_gnt_o,
    output logic [NREQ-1:0]    m_ack_o,
    output logic [NREQ-1:0]    m_err_o,
    output logic [DW-1:0]      m_rd_o,
    output logic               s_req_o,
    output logic               s_we_o,
    output logic [AW-1:0]      s_addr_o,
    output logic [DW-1:0]      s_wd_o,
    input  logic               s_ack_i,
    input  logic [DW-1:0]      s_rd_i
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            busy_s, ack_s, tmo_s, found_s;
    logic [IW-1:0]   pick_s, owner_nxt_s;
    logic [NREQ-1:0] owner_oh_s;
    logic            sel_we_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wd_s;

    assign busy_s      = (state_q == BUSY);
    assign ack_s       = busy_s & s_ack_i;
    assign tmo_s       = busy_s & ~s_ack_i & (cnt_q == 8'(TMO - 1));
    assign owner_oh_s  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    assign owner_nxt_s = (owner_q == IW'(NREQ - 1)) ? {IW{1'b0}} : owner_q + {{(IW-1){1'b0}}, 1'b1};

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            int  idx;
            logic hit;
            idx     = (int'(ptr_q) + k) % NREQ;
            hit     = m_req_i[idx] & ~found_s;
            pick_s  = hit ? IW'(idx) : pick_s;
            found_s = found_s | hit;
        end
    end

    // Owner slice mux for the slave-side request fields.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = {AW{1'b0}};
        sel_wd_s   = {DW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            logic sel;
            sel        = (owner_q == IW'(k));
            sel_we_s   = sel ? m_we_i[k]           : sel_we_s;
            sel_addr_s = sel ? m_addr_i[k*AW +: AW] : sel_addr_s;
            sel_wd_s   = sel ? m_wd_i[k*DW +: DW]   : sel_wd_s;
        end
    end

    // Ack and error depend on the live s_ack so they land in the same cycle.
    assign m_gnt_o  = busy_s ? owner_oh_s : {NREQ{1'b0}};
    assign m_ack_o  = ack_s  ? owner_oh_s : {NREQ{1'b0}};
    assign m_err_o  = tmo_s  ? owner_oh_s : {NREQ{1'b0}};
    assign m_rd_o   = ack_s  ? s_rd_i     : {DW{1'b0}};
    assign s_req_o  = busy_s;
    assign s_we_o   = busy_s ? sel_we_s   : 1'b0;
    assign s_addr_o = busy_s ? sel_addr_s : {AW{1'b0}};
    assign s_wd_o   = busy_s ? sel_wd_s   : {DW{1'b0}};

    // Next-state logic for the transfer FSM, pointer, owner and timeout counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = BUSY;
                    owner_d = pick_s;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (ack_s || tmo_s) begin
                    state_d = IDLE;
                    ptr_d   = owner_nxt_s;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = {IW{1'b0}};
                owner_d = {IW{1'b0}};
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State registers; reset also forces every output low through busy_s.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            ptr_q   <= {IW{1'b0}};
            owner_q <= {IW{1'b0}};
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
